// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_arbiter_pkg;

    // Arbiter FSM states; encodings match the shared pipeline definitions.
    typedef enum logic [1:0] {
        ARB_S_CPU = 2'd0,   // port owned by the MEM stage
        ARB_S_EXT = 2'd1,   // port owned by the external requester
        ARB_S_ACK = 2'd2    // ack cycle; port back with the MEM stage
    } arb_state_e;

    // Width of a saturating counter able to hold 0..starve_max.
    function automatic int starve_cnt_width(input int starve_max);
        return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the pipeline MEM stage
// (priority) and an external loader. A saturating starvation counter
// guarantees the external side a slot after STARVE_MAX contended cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int              CNT_W       = starve_cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0] STARVE_SAT  = CNT_W'(STARVE_MAX);

    arb_state_e             state_reg;
    logic [CNT_W-1:0]       starve_cnt_reg;
    logic                   ext_ack_reg;
    logic [DATA_WIDTH-1:0]  ext_rdata_reg;

    logic                   ext_grant;
    logic                   ext_take;

    // The external side owns the port only during S_EXT.
    assign ext_grant = (state_reg == ARB_S_EXT);

    // Hand the port over when the CPU is idle or has had its fill of cycles.
    assign ext_take = ext_req & (~cpu_req | (starve_cnt_reg == STARVE_LAST));

    assign cpu_rdata = mem_rdata;
    assign ext_ack   = ext_ack_reg;
    assign ext_rdata = ext_rdata_reg;

    // Port mux; writes and stalls are suppressed while reset is held so an
    // in-flight external write is aborted rather than committed.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req & cpu_we;
        cpu_stall = 1'b0;
        if (ext_grant) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_we    = ext_we;
            cpu_stall = cpu_req;
        end
        if (!rst) begin
            mem_we    = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    // FSM with registered ack/read data and the saturating starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ARB_S_CPU;
            starve_cnt_reg <= '0;
            ext_ack_reg    <= 1'b0;
            ext_rdata_reg  <= '0;
        end else begin
            case (state_reg)
                ARB_S_CPU: begin
                    ext_ack_reg <= 1'b0;
                    if (ext_take) begin
                        state_reg <= ARB_S_EXT;
                    end else if (ext_req & cpu_req) begin
                        if (starve_cnt_reg != STARVE_SAT)
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                    end else if (!ext_req) begin
                        starve_cnt_reg <= '0;
                    end
                end
                ARB_S_EXT: begin
                    // Capture read data before a same-edge write lands.
                    ext_rdata_reg  <= mem_rdata;
                    ext_ack_reg    <= 1'b1;
                    starve_cnt_reg <= '0;
                    state_reg      <= ARB_S_ACK;
                end
                ARB_S_ACK: begin
                    // Requester drops ext_req this cycle, so it is ignored.
                    ext_ack_reg <= 1'b0;
                    state_reg   <= ARB_S_CPU;
                end
                default: begin
                    ext_ack_reg <= 1'b0;
                    state_reg   <= ARB_S_CPU;
                end
            endcase
        end
    end

endmodule
